// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-memory arbiter.
// Defaults match the 4-requester, 256x8 memory system.
package mem_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int WIDTH_DEF     = 8;
  localparam int ADDR_W_DEF    = 8;
  localparam int RES_BASE_DEF  = 200;
  localparam int RES_COUNT_DEF = 9;

  localparam int PTR_W_DEF = $clog2(NREQ_DEF);
  localparam int CNT_W_DEF = $clog2(RES_COUNT_DEF + 1);

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic [PTR_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PTR_W'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared single-port data memory:
// one access per cycle, tagged read return, result-window done flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RES_BASE  = RES_BASE_DEF,
  parameter int RES_COUNT = RES_COUNT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic                   done
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(RES_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RES_COUNT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] rd_tag_q, rd_tag_d;
  logic             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             done_q, done_d;

  logic [NREQ-1:0]  gnt;
  logic [PTR_W-1:0] gidx;
  logic             any;
  logic             grant;
  logic             res_hit;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  assign grant = any & ~reset;

  always_comb begin
    req_ready = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      req_ready = gnt;
      mem_en    = 1'b1;
      mem_we    = req_write[gidx];
      mem_addr  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[int'(gidx)*WIDTH +: WIDTH];
    end
  end

  // Read data comes straight off the memory; a reset kills it in flight.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!reset && rd_pend_q) begin
      rsp_valid[rd_tag_q] = 1'b1;
      rsp_rdata           = mem_rdata;
    end
  end

  assign res_hit = mem_en && mem_we &&
                   (int'(mem_addr) >= RES_BASE) &&
                   (int'(mem_addr) < RES_BASE + RES_COUNT);

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rd_pend_d = 1'b0;
    rd_tag_d  = rd_tag_q;
    res_cnt_d = res_cnt_q;
    if (grant) begin
      rr_ptr_d  = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
      rd_pend_d = ~req_write[gidx];
      rd_tag_d  = gidx;
    end
    if (res_hit && res_cnt_q != CNT_MAX) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end
    done_d = done_q | (res_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      rd_tag_q  <= '0;
      rd_pend_q <= 1'b0;
      res_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_tag_q  <= rd_tag_d;
      rd_pend_q <= rd_pend_d;
      res_cnt_q <= res_cnt_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;

endmodule
